// File: rtl/sa_job_scheduler.sv
// Round-robin job scheduler in front of a shared 4x4 systolic array wrapper.
// One requester is granted at a time. Its BEATS operand pairs are buffered,
// then replayed to the array one pair per cycle without stalling. The BEATS
// result bytes are captured and returned to the same requester.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. A producer holds its data stable while valid is high and ready is low.
// in_ready only ever asserts the granted bit, and never depends on in_valid.
// res_valid does not wait for res_ready, and res_data holds its value until
// the byte is accepted.
module sa_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int BEATS   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,          // synchronous, active-high
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   in_valid,
  input  logic [8*NREQ-1:0] in_a,
  input  logic [8*NREQ-1:0] in_b,
  output logic [NREQ-1:0]   in_ready,
  output logic              res_valid,
  output logic [7:0]        res_data,
  output logic              res_last,
  input  logic              res_ready,
  output logic              sa_en,
  output logic [7:0]        sa_in_A,
  output logic [7:0]        sa_in_B,
  input  logic [7:0]        sa_shift_out,
  input  logic              sa_ack,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(BEATS);
  localparam int CW = $clog2(BEATS) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_FIRE     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_COLLECT  = 3'd4,
    S_DRAIN    = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr;            // last winner; also the granted index during a job
  logic [PW-1:0] win, cand;
  logic          found, any_req;
  logic [CW-1:0] cnt;            // shared beat / byte index for the current phase
  logic [TW-1:0] timer;
  logic          sel_valid;
  logic [7:0]    sel_a, sel_b;
  logic          beat_fire, ack_fire, res_fire, abort, step;

  logic [7:0] op_a    [BEATS];
  logic [7:0] op_b    [BEATS];
  logic [7:0] res_buf [BEATS];

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Round-robin search: first requesting index above the last winner, wrapping.
  always_comb begin
    any_req = |req;
    found   = 1'b0;
    win     = ptr;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Route the granted requester's operand lane to the buffer write port.
  always_comb begin
    sel_valid = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == ptr) begin
        sel_valid = in_valid[i];
        sel_a     = in_a[8*i +: 8];
        sel_b     = in_b[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next state, handshake strobes and array/result outputs.
  always_comb begin
    state_next = state;
    in_ready   = '0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_last   = 1'b0;
    sa_en      = 1'b0;
    sa_in_A    = '0;
    sa_in_B    = '0;
    beat_fire  = 1'b0;
    ack_fire   = 1'b0;
    res_fire   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) state_next = S_FILL;
      end
      S_FILL: begin
        in_ready = gnt;
        if (sel_valid) begin
          beat_fire = 1'b1;
          if (cnt == LAST) state_next = S_FIRE;
        end
      end
      S_FIRE: begin
        sa_en   = (cnt == '0);
        sa_in_A = op_a[cnt[AW-1:0]];
        sa_in_B = op_b[cnt[AW-1:0]];
        if (cnt == LAST) state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (sa_ack) begin
          ack_fire   = 1'b1;
          state_next = S_COLLECT;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (sa_ack) begin
          ack_fire = 1'b1;
          if (cnt == LAST) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_valid = 1'b1;
        res_data  = res_buf[cnt[AW-1:0]];
        res_last  = (cnt == LAST);
        if (res_ready) begin
          res_fire = 1'b1;
          if (cnt == LAST) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Every phase walks cnt from 0 to BEATS-1 and wraps back to 0 on its last step.
  assign step = beat_fire | (state == S_FIRE) | ack_fire | res_fire;

  // Grant, pointer, counters and the abort pulse.
  always_ff @(posedge clk) begin
    if (rstn) begin
      gnt         <= '0;
      ptr         <= PW'(NREQ - 1);
      cnt         <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if (state == S_IDLE && any_req) begin
        gnt <= NREQ'(1) << win;
        ptr <= win;
        cnt <= '0;
      end else if (step) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
      if (abort || (res_fire && cnt == LAST)) gnt <= '0;
      if (state == S_WAIT_ACK) timer <= timer + TW'(1);
      else                     timer <= '0;
    end
  end

  // Operand and result storage; contents are don't-care outside a job.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      op_a[cnt[AW-1:0]] <= sel_a;
      op_b[cnt[AW-1:0]] <= sel_b;
    end
    if (ack_fire) res_buf[cnt[AW-1:0]] <= sa_shift_out;
  end

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Bench for sa_job_scheduler: a table of complete jobs, then hand-written
// timeout, stray-ack and mid-job reset sequences.
module tb_sa_job_scheduler;

  localparam int NREQ    = 2;
  localparam int BEATS   = 16;
  localparam int TIMEOUT = 255;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  gnt;
  logic [1:0]  in_valid = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [1:0]  in_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_last;
  logic        res_ready = 1'b0;
  logic        sa_en;
  logic [7:0]  sa_in_A, sa_in_B;
  logic [7:0]  sa_shift_out = '0;
  logic        sa_ack = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  sa_job_scheduler #(.NREQ(NREQ), .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
    .sa_en(sa_en), .sa_in_A(sa_in_A), .sa_in_B(sa_in_B),
    .sa_shift_out(sa_shift_out), .sa_ack(sa_ack),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int gnt_viol = 0;
  logic [15:0] exp_q[$];   // operand pairs {A,B} expected on the array side
  logic [7:0]  res_q[$];   // result bytes expected on the requester side

  typedef struct {
    logic [1:0] req;
    bit         hold;        // keep req asserted for the whole job
    logic [1:0] exp_gnt;
    logic [7:0] a0, b0, rbase;
    int         delay, gap_at, gap_len, extra;
    bit         valid_tog, ready_13;
  } job_vec_t;

  job_vec_t vecs[7];

  // Grant must never have more than one bit set.
  always @(negedge clk) if (!rstn && $countones(gnt) > 1) gnt_viol++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return {31'b0, gnt, in_ready, res_valid, res_last, res_data, sa_en,
            sa_in_A, sa_in_B, busy, timeout_err};
  endfunction

  task automatic wait_gnt(input logic [1:0] exp);
    int c;
    c = 0;
    while (gnt == 2'b00 && c < 20) begin
      tick();
      c++;
    end
    check("grant", 64'(gnt), 64'(exp));
  endtask

  task automatic fill_job(input int r, input logic [7:0] a0, input logic [7:0] b0, input bit tog);
    int sent, cyc, other;
    logic v, rdy;
    logic [7:0] a, b;
    sent  = 0;
    cyc   = 0;
    other = 1 - r;
    while (sent < BEATS && cyc < 200) begin
      a = a0 + 8'(sent);
      b = b0 - 8'(sent);
      v = tog ? (cyc % 2 == 0) : 1'b1;
      in_valid        = '0;
      in_valid[r]     = v;
      in_valid[other] = 1'b1;          // must be ignored
      in_a[r*8 +: 8]     = a;
      in_b[r*8 +: 8]     = b;
      in_a[other*8 +: 8] = 8'hEE;
      in_b[other*8 +: 8] = 8'hDD;
      rdy = in_ready[r];
      if (cyc == 0) check("fill_in_ready", 64'(in_ready), 64'(2'b01 << r));
      tick();
      if (rdy && v) begin
        exp_q.push_back({a, b});
        sent++;
      end
      cyc++;
    end
    in_valid = '0;
    check("fill_beats", 64'(sent), 64'(BEATS));
  endtask

  task automatic fire_check();
    logic [15:0] pair;
    for (int k = 0; k < BEATS; k++) begin
      check("fire_sa_en", 64'(sa_en), 64'(k == 0));
      if (k == 0) check("fire_in_ready", 64'(in_ready), 64'(0));
      pair = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("fire_operands", 64'({sa_in_A, sa_in_B}), 64'(pair));
      tick();
    end
    check("post_fire_idle_bus", 64'({sa_en, sa_in_A, sa_in_B}), 64'(0));
  endtask

  task automatic ack_phase(input logic [7:0] rbase, input int delay, input int gap_at,
                           input int gap_len, input int extra);
    sa_ack = 1'b0;
    repeat (delay) tick();
    for (int k = 0; k < BEATS; k++) begin
      if (gap_at != 0 && k == gap_at) begin
        sa_ack = 1'b0;
        repeat (gap_len) tick();
      end
      sa_ack       = 1'b1;
      sa_shift_out = rbase + 8'(k);
      res_q.push_back(rbase + 8'(k));
      tick();
    end
    for (int e = 0; e < extra; e++) begin
      sa_ack       = 1'b1;
      sa_shift_out = 8'hA5;            // must be dropped
      tick();
    end
    sa_ack = 1'b0;
  endtask

  task automatic drain(input bit ready_13);
    int idx, cyc;
    logic rv, rr;
    idx = 0;
    cyc = 0;
    while (idx < BEATS && cyc < 300) begin
      rv = res_valid;
      if (rv) begin
        check("res_data", 64'(res_data), 64'((res_q.size() > 0) ? res_q[0] : 8'hxx));
        check("res_last", 64'(res_last), 64'(idx == BEATS - 1));
      end
      rr = ready_13 ? (cyc % 3 == 0) : 1'b1;
      res_ready = rr;
      tick();
      if (rv && rr) begin
        if (res_q.size() > 0) void'(res_q.pop_front());
        idx++;
      end
      cyc++;
    end
    res_ready = 1'b0;
    check("drain_count", 64'(idx), 64'(BEATS));
    check("post_job_idle", 64'({busy, gnt, res_valid}), 64'(0));
  endtask

  task automatic run_row(input job_vec_t v);
    int r;
    r = v.exp_gnt[1] ? 1 : 0;
    exp_q.delete();
    res_q.delete();
    req = v.req;
    wait_gnt(v.exp_gnt);
    if (!v.hold) req = 2'b00;           // deassert mid-job: must be ignored
    fill_job(r, v.a0, v.b0, v.valid_tog);
    fire_check();
    ack_phase(v.rbase, v.delay, v.gap_at, v.gap_len, v.extra);
    drain(v.ready_13);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    //          req    hold  gnt    a0     b0     rbase  dly gap_at gap_len extra tog r13
    vecs[0] = '{2'b01, 1'b0, 2'b01, 8'h01, 8'h10, 8'h10, 5,  0,     0,      0,    1'b0, 1'b0};
    vecs[1] = '{2'b10, 1'b0, 2'b10, 8'h20, 8'h30, 8'h50, 1,  0,     0,      0,    1'b0, 1'b0};
    vecs[2] = '{2'b11, 1'b1, 2'b01, 8'h60, 8'h61, 8'h70, 3,  0,     0,      0,    1'b0, 1'b0};
    vecs[3] = '{2'b11, 1'b1, 2'b10, 8'h80, 8'h90, 8'hA0, 0,  0,     0,      0,    1'b0, 1'b0};
    vecs[4] = '{2'b11, 1'b1, 2'b01, 8'hC0, 8'hC1, 8'hD0, 7,  0,     0,      0,    1'b0, 1'b0};
    vecs[5] = '{2'b11, 1'b0, 2'b10, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 4, 0, 0, 0, 1'b1, 1'b1};
    vecs[6] = '{2'b01, 1'b0, 2'b01, 8'h33, 8'h44, 8'hE0, 2,  8,     3,      2,    1'b0, 1'b0};

    // Reset dominates a pending request.
    rstn = 1'b1;
    req  = 2'b01;
    repeat (3) tick();
    check("reset_outputs", outs(), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(0));
    rstn = 1'b0;
    req  = 2'b00;
    tick();

    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // Timeout: array never acknowledges.
    exp_q.delete();
    req = 2'b01;
    wait_gnt(2'b01);
    req = 2'b00;
    fill_job(0, 8'h40, 8'h80, 1'b0);
    fire_check();
    c = 0;
    while (!timeout_err && c < 400) begin
      tick();
      c++;
    end
    check("timeout_latency", 64'(c), 64'(TIMEOUT));
    check("timeout_idle", 64'({busy, gnt}), 64'(0));
    tick();
    check("timeout_pulse_width", 64'(timeout_err), 64'(0));

    // Stray ack while idle changes nothing.
    sa_ack       = 1'b1;
    sa_shift_out = 8'h77;
    tick();
    sa_ack = 1'b0;
    check("stray_ack_state", 64'({state_dbg, busy, res_valid}), 64'(0));

    // Reset in the middle of COLLECT.
    exp_q.delete();
    req = 2'b10;
    wait_gnt(2'b10);
    req = 2'b00;
    fill_job(1, 8'h05, 8'h06, 1'b0);
    fire_check();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      sa_ack       = 1'b1;
      sa_shift_out = 8'h90 + 8'(k);
      tick();
    end
    sa_ack = 1'b0;
    check("mid_collect_state", 64'(state_dbg), 64'(4));
    rstn = 1'b1;
    tick();
    check("midjob_reset_outputs", outs(), 64'(0));
    check("midjob_reset_state", 64'(state_dbg), 64'(0));
    rstn = 1'b0;
    req  = 2'b11;
    wait_gnt(2'b01);                   // pointer reset: requester 0 wins
    req = 2'b00;

    check("gnt_onehot_violations", 64'(gnt_viol), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
